bullet_sequencer: RTL

//  Sequences one player shot through the 8x8 tile map: launch, row-by-row flight, collision test, pop request.

---
 rtl/bullet_sequencer_pkg.sv | 16 +
 rtl/edge_detect.sv | 18 +
 rtl/bullet_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/bullet_sequencer_pkg.sv
// Shared game constants: tile indices, map row indices and the shot FSM encodings.
package bullet_sequencer_pkg;

    localparam logic [4:0] DARK             = 5'd0;
    localparam logic [4:0] TILE_BASE_BULLET = 5'd13;

    localparam logic [2:0] SCORE_ROW  = 3'd0;
    localparam logic [2:0] BUBBLE_TOP = 3'd1;
    localparam logic [2:0] PLAYER_ROW = 3'd7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FLY  = 2'd1;
    localparam logic [1:0] HIT  = 2'd2;
    localparam logic [1:0] COOL = 2'd3;

endpackage

// File: rtl/edge_detect.sv
// 1-bit rising-edge detector; also used for the en button in the game manager.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/bullet_sequencer.sv
// One player shot: launch, row-by-row flight on step ticks, collision test, pop handshake, cooldown.
module bullet_sequencer
    import bullet_sequencer_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int BROWS      = 4,
    parameter int START_ROW  = 6,
    parameter int COOL_STEPS = 2,
    parameter int TILE_BASE  = int'(TILE_BASE_BULLET)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  step,
    input  logic                  fire,
    input  logic [2:0]            player_col,
    input  logic [1:0]            player_clr,
    input  logic [BROWS*COLS-1:0] bubble_occ,
    output logic                  pop_valid,
    output logic [1:0]            pop_row,
    output logic [2:0]            pop_col,
    output logic [1:0]            pop_clr,
    input  logic                  pop_ready,
    input  logic                  pop_done,
    output logic                  score_inc,
    output logic                  bullet_vis,
    output logic [2:0]            bullet_row,
    output logic [2:0]            bullet_col,
    output logic [4:0]            bullet_tile
);

    localparam int CW = (COOL_STEPS > 0) ? $clog2(COOL_STEPS + 1) : 1;

    logic [1:0]    state;
    logic [2:0]    row, col, tgt, row_up, tgt_m1;
    logic [1:0]    clr;
    logic [CW-1:0] cnt;
    logic          fire_edge, occ_here, occ_above;

    edge_detect u_fire_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (fire),
        .rise (fire_edge)
    );

    // Occupancy of map row r (bubble rows only), column c; non-bubble rows read as empty.
    function automatic logic occ_at(input logic [BROWS*COLS-1:0] occ,
                                    input logic [2:0] r, input logic [2:0] c);
        logic [BROWS*COLS-1:0] sh;
        sh = occ >> ((int'(r) - 1) * COLS + int'(c));
        return (r >= BUBBLE_TOP) && (int'(r) <= BROWS) && sh[0];
    endfunction

    assign row_up    = row - 3'd1;
    assign occ_here  = occ_at(bubble_occ, row, col);
    assign occ_above = occ_at(bubble_occ, row_up, col);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            clr   <= '0;
            tgt   <= '0;
            cnt   <= '0;
        end else if (!active) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (fire_edge) begin
                    state <= FLY;
                    row   <= 3'(START_ROW);
                    col   <= player_col;
                    clr   <= player_clr;
                end
                FLY: begin
                    // A bubble landing on the bullet's own cell wins over any step this cycle.
                    if (occ_here) begin
                        state <= HIT;
                        tgt   <= row;
                    end else if (step) begin
                        if (occ_above) begin
                            state <= HIT;
                            tgt   <= row_up;
                        end else if (row_up == SCORE_ROW) begin
                            state <= COOL;
                            cnt   <= CW'(COOL_STEPS);
                        end else begin
                            row <= row_up;
                        end
                    end
                end
                HIT: if (pop_ready) begin
                    state <= COOL;
                    cnt   <= CW'(COOL_STEPS);
                end
                default: begin
                    if (cnt == '0)  state <= IDLE;
                    else if (step)  cnt   <= cnt - 1'b1;
                end
            endcase
        end
    end

    assign tgt_m1      = tgt - 3'd1;
    assign pop_valid   = (state == HIT);
    assign pop_row     = pop_valid ? tgt_m1[1:0] : 2'd0;
    assign pop_col     = pop_valid ? col : 3'd0;
    assign pop_clr     = pop_valid ? clr : 2'd0;
    assign score_inc   = pop_valid & pop_ready & pop_done;

    assign bullet_vis  = (state == FLY) || (state == HIT);
    assign bullet_row  = bullet_vis ? row : 3'd0;
    assign bullet_col  = bullet_vis ? col : 3'd0;
    assign bullet_tile = 5'(TILE_BASE) + (bullet_vis ? {3'b000, clr} : 5'd0);

endmodule
